// File: rtl/hash_mem_responder.sv
// Memory-side responder for the bitcoin_hash miner: owns the word SRAM, serves
// the miner's one-cycle-latency mem port, and sequences load/start/run/dump jobs.
module hash_mem_responder #(
  parameter int unsigned DEPTH     = 256,
  parameter int unsigned MSG_ADDR  = 0,
  parameter int unsigned MSG_WORDS = 20,
  parameter int unsigned OUT_ADDR  = 32,
  parameter int unsigned OUT_WORDS = 16,
  parameter int unsigned TIMEOUT   = 65535
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        host_in_valid,
  input  logic [31:0] host_in_data,
  output logic        host_in_ready,
  output logic        host_out_valid,
  output logic [31:0] host_out_data,
  output logic        host_out_last,
  input  logic        host_out_ready,
  output logic        miner_reset_n,
  output logic        miner_start,
  input  logic        miner_done,
  output logic [15:0] message_addr,
  output logic [15:0] output_addr,
  input  logic        mem_we,
  input  logic [15:0] mem_addr,
  input  logic [31:0] mem_write_data,
  output logic [31:0] mem_read_data,
  output logic        busy,
  output logic        err,
  output logic [2:0]  state_dbg
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW-1:0] MSG_BASE = AW'(MSG_ADDR);
  localparam logic [AW-1:0] OUT_BASE = AW'(OUT_ADDR);
  localparam logic [AW-1:0] MSG_LAST = AW'(MSG_WORDS - 1);
  localparam logic [AW-1:0] OUT_LAST = AW'(OUT_WORDS - 1);

  if ((MSG_ADDR + MSG_WORDS > DEPTH) || (OUT_ADDR + OUT_WORDS > DEPTH) ||
      (DEPTH > 65536)) begin : g_bad_params
    $error("hash_mem_responder: message/output window exceeds DEPTH");
  end

  typedef enum logic [2:0] {
    S_LOAD  = 3'd0,
    S_PRIME = 3'd1,
    S_START = 3'd2,
    S_RUN   = 3'd3,
    S_DUMP  = 3'd4
  } state_t;

  state_t        state;
  logic [31:0]   mem [DEPTH];
  logic [AW-1:0] cnt;
  logic [AW-1:0] idx;
  logic [31:0]   wdog;
  logic          host_wr;
  logic          miner_in_range;
  logic          miner_wr;

  assign message_addr = 16'(MSG_ADDR);
  assign output_addr  = 16'(OUT_ADDR);
  assign state_dbg    = state;

  // Both streams use valid/ready: a word moves on a rising edge where valid and
  // ready are both high; the sender holds data stable while valid && !ready.
  assign host_wr        = (state == S_LOAD) && host_in_ready && host_in_valid;
  assign miner_in_range = 32'(mem_addr) < DEPTH;
  assign miner_wr       = mem_we && miner_in_range && (state == S_RUN) && !host_wr;

  always_ff @(posedge clk) begin
    if (reset_n) begin
      if (host_wr) begin
        mem[MSG_BASE + cnt] <= host_in_data;
      end else if (miner_wr) begin
        mem[mem_addr[AW-1:0]] <= mem_write_data;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state          <= S_LOAD;
      cnt            <= '0;
      idx            <= '0;
      wdog           <= '0;
      host_in_ready  <= 1'b0;
      host_out_valid <= 1'b0;
      host_out_data  <= '0;
      host_out_last  <= 1'b0;
      miner_reset_n  <= 1'b0;
      miner_start    <= 1'b0;
      mem_read_data  <= '0;
      busy           <= 1'b0;
      err            <= 1'b0;
    end else begin
      miner_reset_n <= 1'b1;
      miner_start   <= 1'b0;
      // Read-first: the array still holds the pre-write value on this edge.
      mem_read_data <= miner_in_range ? mem[mem_addr[AW-1:0]] : 32'd0;
      if (!miner_in_range || (mem_we && state != S_RUN)) begin
        err <= 1'b1;
      end
      case (state)
        S_LOAD: begin
          host_in_ready <= 1'b1;
          if (host_wr) begin
            cnt <= cnt + 1'b1;
            if (cnt == MSG_LAST) begin
              state         <= S_PRIME;
              host_in_ready <= 1'b0;
              miner_reset_n <= 1'b0;
              busy          <= 1'b1;
            end
          end
        end
        S_PRIME: begin
          state       <= S_START;
          miner_start <= 1'b1;
        end
        S_START: begin
          state <= S_RUN;
          wdog  <= '0;
        end
        S_RUN: begin
          if (miner_done) begin
            state <= S_DUMP;
          end else begin
            wdog <= wdog + 32'd1;
            if (wdog + 32'd1 == TIMEOUT) begin
              err   <= 1'b1;
              state <= S_DUMP;
            end
          end
        end
        S_DUMP: begin
          // A low-valid cycle issues the next read; the word is then held until taken.
          if (!host_out_valid) begin
            host_out_data  <= mem[OUT_BASE + idx];
            host_out_last  <= (idx == OUT_LAST);
            host_out_valid <= 1'b1;
          end else if (host_out_ready) begin
            host_out_valid <= 1'b0;
            host_out_last  <= 1'b0;
            if (host_out_last) begin
              state         <= S_LOAD;
              idx           <= '0;
              cnt           <= '0;
              host_in_ready <= 1'b1;
              busy          <= 1'b0;
            end else begin
              idx <= idx + 1'b1;
            end
          end
        end
        default: state <= S_LOAD;
      endcase
    end
  end

endmodule

// File: tb/tb_hash_mem_responder.sv
// Bench for hash_mem_responder: randomized jobs against a word-array memory model,
// with a queue-based scoreboard checking the result stream.
module tb_hash_mem_responder;
  localparam int TMO = 100;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        host_in_valid = 1'b0;
  logic [31:0] host_in_data = '0;
  logic        host_in_ready;
  logic        host_out_valid;
  logic [31:0] host_out_data;
  logic        host_out_last;
  logic        host_out_ready;
  logic        miner_reset_n;
  logic        miner_start;
  logic        miner_done = 1'b0;
  logic [15:0] message_addr;
  logic [15:0] output_addr;
  logic        mem_we = 1'b0;
  logic [15:0] mem_addr = '0;
  logic [31:0] mem_write_data = '0;
  logic [31:0] mem_read_data;
  logic        busy;
  logic        err;
  logic [2:0]  state_dbg;

  hash_mem_responder #(.TIMEOUT(TMO)) dut (
    .clk(clk), .reset_n(reset_n),
    .host_in_valid(host_in_valid), .host_in_data(host_in_data), .host_in_ready(host_in_ready),
    .host_out_valid(host_out_valid), .host_out_data(host_out_data),
    .host_out_last(host_out_last), .host_out_ready(host_out_ready),
    .miner_reset_n(miner_reset_n), .miner_start(miner_start), .miner_done(miner_done),
    .message_addr(message_addr), .output_addr(output_addr),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_write_data(mem_write_data),
    .mem_read_data(mem_read_data), .busy(busy), .err(err), .state_dbg(state_dbg)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  // ---------------- scoreboard state ----------------
  int          tests = 0;
  int          fails = 0;
  logic [32:0] exp_q[$];
  logic [31:0] ref_mem[256];
  int          words_seen = 0;
  int          hold_cnt = 0;
  bit          hold_word3 = 1'b0;
  bit          rand_bp = 1'b1;
  int          start_cyc = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // ---------------- host_out_ready driver ----------------
  initial begin
    host_out_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (hold_word3 && words_seen == 3 && host_out_valid && hold_cnt < 5) begin
        host_out_ready = 1'b0;
        hold_cnt++;
      end else begin
        host_out_ready = rand_bp ? ($urandom_range(0, 3) != 0) : 1'b1;
      end
    end
  end

  // ---------------- monitor ----------------
  bit          prev_stall = 1'b0;
  bit          prev_hs = 1'b0;
  logic [31:0] prev_data = '0;
  logic        prev_last = 1'b0;

  always @(negedge clk) begin
    if (!reset_n) begin
      prev_stall = 1'b0;
      prev_hs    = 1'b0;
    end else begin
      logic [32:0] e;
      bit hs;
      if (prev_stall) begin
        check("held word under backpressure", {host_out_valid, host_out_last, host_out_data},
              {1'b1, prev_last, prev_data});
      end
      if (prev_hs) check("valid gap after handshake", host_out_valid, 1'b0);
      hs = host_out_valid && host_out_ready;
      if (hs) begin
        if (exp_q.size() == 0) begin
          check("unexpected result word", {host_out_last, host_out_data}, 33'h0_0000_0000);
        end else begin
          e = exp_q.pop_front();
          check($sformatf("result word %0d", words_seen), {host_out_last, host_out_data}, e);
        end
        words_seen++;
      end
      prev_stall = host_out_valid && !host_out_ready;
      prev_data  = host_out_data;
      prev_last  = host_out_last;
      prev_hs    = hs;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic mwrite(input logic [15:0] addr, input logic [31:0] data, input bit in_run);
    mem_we = 1'b1;
    mem_addr = addr;
    mem_write_data = data;
    step();
    mem_we = 1'b0;
    mem_addr = '0;
    if (in_run && addr < 16'd256) ref_mem[addr[7:0]] = data;
  endtask

  task automatic mread(input logic [15:0] addr, input string name);
    mem_addr = addr;
    step();
    check(name, mem_read_data, (addr < 16'd256) ? ref_mem[addr[7:0]] : 32'd0);
    mem_addr = '0;
  endtask

  task automatic load_job(input bit seq, input bit bad_write);
    logic [31:0] w;
    int guard;
    for (int k = 0; k < 20; k++) begin
      w = seq ? 32'(k + 1) : $urandom();
      repeat ($urandom_range(0, 2)) step();
      if (bad_write && k == 5) begin
        mwrite(16'd33, $urandom(), 1'b0);
        check("miner write outside RUN sets err", err, 1'b1);
      end
      host_in_valid = 1'b1;
      host_in_data = w;
      guard = 0;
      while (!host_in_ready && guard < 20) begin
        step();
        guard++;
      end
      if (!host_in_ready) check("host_in_ready during LOAD", host_in_ready, 1'b1);
      step();
      host_in_valid = 1'b0;
      ref_mem[k] = w;
    end
    check("prime cycle {miner_reset_n,busy,in_ready,start}",
          {miner_reset_n, busy, host_in_ready, miner_start}, 4'b0100);
    step();
    check("start cycle {start,miner_reset_n,busy}", {miner_start, miner_reset_n, busy}, 3'b111);
    start_cyc = cyc;
    step();
    check("start pulse is one cycle", miner_start, 1'b0);
  endtask

  task automatic push_expected();
    for (int i = 0; i < 16; i++) exp_q.push_back({(i == 15), ref_mem[32 + i]});
  endtask

  task automatic raise_done();
    int t0;
    int guard;
    push_expected();
    miner_done = 1'b1;
    t0 = cyc;
    guard = 0;
    while (!host_out_valid && guard < 50) begin
      step();
      guard++;
    end
    check("done to first valid latency", cyc - t0, 2);
    miner_done = 1'b0;
  endtask

  task automatic finish_dump();
    int guard;
    guard = 0;
    while (exp_q.size() != 0 && guard < 400) begin
      step();
      guard++;
    end
    check("all result words delivered", exp_q.size(), 0);
    check("back in LOAD {in_ready,busy}", {host_in_ready, busy}, 2'b10);
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    step();
    reset_n = 1'b1;
    step();
    check("after reset {in_ready,miner_reset_n,err}", {host_in_ready, miner_reset_n, err}, 3'b110);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int guard;
    reset_n = 1'b0;
    repeat (3) step();
    check("reset outputs A", {host_in_ready, host_out_valid, host_out_last, miner_reset_n,
                              miner_start, busy, err}, 7'd0);
    check("reset outputs B", {host_out_data, mem_read_data}, 64'd0);
    check("message_addr", message_addr, 16'd0);
    check("output_addr", output_addr, 16'd32);
    reset_n = 1'b1;
    step();
    check("release {in_ready,miner_reset_n,busy}", {host_in_ready, miner_reset_n, busy}, 3'b110);

    // Job A: known data, word-3 backpressure, read latency and read-first.
    words_seen = 0; hold_cnt = 0; hold_word3 = 1'b1; rand_bp = 1'b1;
    load_job(1'b1, 1'b0);
    for (int i = 0; i < 16; i++) mwrite(16'(32 + i), 32'hA000_0000 + 32'(i), 1'b1);
    mread(16'd5, "read latency addr 5");
    check("addr 5 holds message word 6", ref_mem[5], 32'h0000_0006);
    mem_we = 1'b1; mem_addr = 16'd40; mem_write_data = 32'h1234_5678;
    step();
    mem_we = 1'b0; mem_addr = '0;
    check("read-first on same-address write", mem_read_data, 32'hA000_0008);
    ref_mem[40] = 32'h1234_5678;
    mread(16'd40, "read after write");
    mwrite(16'd40, 32'hA000_0008, 1'b1);
    raise_done();
    finish_dump();
    check("job A err", err, 1'b0);
    check("word 3 held for 5 cycles", hold_cnt, 5);
    hold_word3 = 1'b0;

    // Job B: watchdog timeout, partial results.
    words_seen = 0;
    load_job(1'b0, 1'b0);
    for (int i = 0; i < 8; i++) mwrite(16'(32 + i), $urandom(), 1'b1);
    push_expected();
    guard = 0;
    while (!host_out_valid && guard < 300) begin
      step();
      guard++;
    end
    check("timeout: start to first valid", cyc - start_cyc, TMO + 2);
    check("timeout sets err", err, 1'b1);
    finish_dump();
    check("err sticky after dump", err, 1'b1);
    do_reset();

    // Job C: dropped writes outside RUN and out of range.
    words_seen = 0;
    load_job(1'b0, 1'b1);
    for (int i = 0; i < 16; i++) if (i != 1) mwrite(16'(32 + i), $urandom(), 1'b1);
    mwrite(16'd300, $urandom(), 1'b1);
    raise_done();
    finish_dump();
    do_reset();

    // Job D: out-of-range access then reset during RUN.
    load_job(1'b0, 1'b0);
    check("err clear before oob", err, 1'b0);
    mwrite(16'd300, 32'hDEAD_BEEF, 1'b1);
    check("oob write sets err", err, 1'b1);
    mread(16'd300, "oob read returns 0");
    reset_n = 1'b0;
    step();
    check("mid-run reset outputs A", {host_in_ready, host_out_valid, host_out_last, miner_reset_n,
                                      miner_start, busy, err}, 7'd0);
    check("mid-run reset outputs B", {host_out_data, mem_read_data}, 64'd0);
    reset_n = 1'b1;
    step();
    check("mid-run release {in_ready,miner_reset_n,busy}", {host_in_ready, miner_reset_n, busy},
          3'b110);

    // Job E: full random job after the mid-run reset.
    words_seen = 0;
    load_job(1'b0, 1'b0);
    for (int i = 0; i < 16; i++) mwrite(16'(32 + i), $urandom(), 1'b1);
    mread(16'd7, "read latency addr 7");
    raise_done();
    finish_dump();
    check("job E err", err, 1'b0);

    repeat (4) step();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #400000;
    fails++;
    $display("FAIL global time limit: got no end, expected completion");
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $fatal(1);
  end

endmodule
